// File: rtl/vga_plot_arbiter_pkg.sv
// rtl/vga_plot_arbiter_pkg.sv - shared widths, screen limits, colours and state codes
package vga_plot_arbiter_pkg;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int IDX_W = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [C_W-1:0] BLACK = 3'b000;
  localparam logic [C_W-1:0] BLUE  = 3'b001;
  localparam logic [C_W-1:0] WHITE = 3'b111;

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating-priority one-hot selector starting at ptr
module rr_priority_pick
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter with burst lock for the VGA write port
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*X_W-1:0] x_in,
  input  logic [NREQ*Y_W-1:0] y_in,
  input  logic [NREQ*C_W-1:0] colour_in,
  output logic [NREQ-1:0]     ack,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [C_W-1:0]      vga_colour,
  output logic                vga_plot,
  output logic [IDX_W-1:0]    grant_id,
  output logic                locked
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;

  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] win;
  logic             xfer;
  logic             lock_w;
  logic [X_W-1:0]   x_w;
  logic [Y_W-1:0]   y_w;
  logic [C_W-1:0]   c_w;
  logic             visible;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) >= NREQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // While locked only the owner may be acked; reset suppresses every ack.
  always_comb begin
    ack = '0;
    win = pick_idx;
    if (!reset) begin
      if (state == LOCKED) begin
        win = owner;
        for (int i = 0; i < NREQ; i++)
          if (IDX_W'(i) == owner) ack[i] = req[i];
      end else begin
        ack = pick_grant;
      end
    end
  end

  assign xfer = |(req & ack);

  always_comb begin
    x_w    = '0;
    y_w    = '0;
    c_w    = '0;
    lock_w = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == win) begin
        x_w    = x_in[i*X_W +: X_W];
        y_w    = y_in[i*Y_W +: Y_W];
        c_w    = colour_in[i*C_W +: C_W];
        lock_w = lock[i];
      end
    end
  end

  assign visible = (int'(x_w) < X_MAX) && (int'(y_w) < Y_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ARB;
      ptr        <= '0;
      owner      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= BLACK;
      vga_plot   <= 1'b0;
      grant_id   <= '0;
    end else begin
      vga_plot <= xfer & visible;
      if (xfer) begin
        vga_x      <= x_w;
        vga_y      <= y_w;
        vga_colour <= c_w;
        grant_id   <= win;
        ptr        <= wrap_inc(win);
        if (lock_w) begin
          state <= LOCKED;
          owner <= win;
        end else begin
          state <= ARB;
        end
      end else if (state == LOCKED && !lock_w) begin
        // Owner dropped both req and lock: release without a transfer.
        state <= ARB;
        ptr   <= wrap_inc(owner);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
  import vga_plot_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  lock = '0;
  logic [23:0] x_in = '0;
  logic [20:0] y_in = '0;
  logic [8:0]  colour_in = '0;
  logic [2:0]  ack;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [2:0]  grant_id;
  logic        locked;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter #(.NREQ(3), .X_MAX(160), .Y_MAX(120)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .ack        (ack),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .grant_id   (grant_id),
    .locked     (locked)
  );

  task automatic set_px(input int i, input int x, input int y, input logic [2:0] c);
    x_in[i*8 +: 8]      = 8'(x);
    y_in[i*7 +: 7]      = 7'(y);
    colour_in[i*3 +: 3] = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b111;
    lock  = '0;
    set_px(0, 1, 2, BLUE);
    set_px(1, 3, 4, BLUE);
    set_px(2, 5, 6, BLUE);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack got=%b exp=000", ack); end
      @(posedge clk); #1;
      n_cmp++; if (vga_plot !== 1'b0) begin n_bad++; $display("FAIL reset_plot got=%b exp=0", vga_plot); end
      n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (ack !== 3'b001) begin n_bad++; $display("FAIL first_ack got=%b exp=001", ack); end
    @(posedge clk); #1;
    n_cmp++; if (vga_plot !== 1'b1) begin n_bad++; $display("FAIL first_plot got=%b exp=1", vga_plot); end
    n_cmp++; if (vga_x !== 8'd1) begin n_bad++; $display("FAIL first_x got=%0d exp=1", vga_x); end
    n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL first_grant got=%0d exp=0", grant_id); end
  endtask

  task automatic test_alternate();
    int exp_w;
    do_reset();
    set_px(0, 10, 20, BLUE);
    set_px(2, 30, 40, WHITE);
    req  = 3'b101;
    lock = '0;
    n_cmp++; if (vga_plot !== 1'b0) begin n_bad++; $display("FAIL alt_preplot got=%b exp=0", vga_plot); end
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 0 : 2;
      @(negedge clk);
      n_cmp++; if (ack !== 3'(1 << exp_w)) begin n_bad++; $display("FAIL alt_ack[%0d] got=%b exp=%b", k, ack, 3'(1 << exp_w)); end
      @(posedge clk); #1;
      n_cmp++; if (vga_plot !== 1'b1) begin n_bad++; $display("FAIL alt_plot[%0d] got=%b exp=1", k, vga_plot); end
      n_cmp++; if (grant_id !== 3'(exp_w)) begin n_bad++; $display("FAIL alt_grant[%0d] got=%0d exp=%0d", k, grant_id, exp_w); end
      n_cmp++; if (vga_x !== (exp_w == 0 ? 8'd10 : 8'd30)) begin n_bad++; $display("FAIL alt_x[%0d] got=%0d", k, vga_x); end
      n_cmp++; if (vga_y !== (exp_w == 0 ? 7'd20 : 7'd40)) begin n_bad++; $display("FAIL alt_y[%0d] got=%0d", k, vga_y); end
      n_cmp++; if (vga_colour !== (exp_w == 0 ? BLUE : WHITE)) begin n_bad++; $display("FAIL alt_colour[%0d] got=%b", k, vga_colour); end
    end
    req = '0;
    @(negedge clk);
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL idle_ack got=%b exp=000", ack); end
    @(posedge clk); #1;
    n_cmp++; if (vga_plot !== 1'b0) begin n_bad++; $display("FAIL idle_plot got=%b exp=0", vga_plot); end
  endtask

  task automatic test_lock();
    do_reset();
    set_px(0, 1, 1, BLUE);
    set_px(2, 2, 2, BLUE);
    for (int k = 0; k < 5; k++) begin
      set_px(1, 50 + k, 60, WHITE);
      req  = (k == 0) ? 3'b010 : 3'b111;
      lock = (k == 4) ? 3'b000 : 3'b010;
      @(negedge clk);
      n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL lock_ack[%0d] got=%b exp=010", k, ack); end
      n_cmp++; if (locked !== (k > 0)) begin n_bad++; $display("FAIL lock_state[%0d] got=%b exp=%b", k, locked, k > 0); end
      @(posedge clk); #1;
      n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL lock_grant[%0d] got=%0d exp=1", k, grant_id); end
      n_cmp++; if (vga_x !== 8'(50 + k)) begin n_bad++; $display("FAIL lock_x[%0d] got=%0d exp=%0d", k, vga_x, 50 + k); end
      n_cmp++; if (vga_plot !== 1'b1) begin n_bad++; $display("FAIL lock_plot[%0d] got=%b exp=1", k, vga_plot); end
    end
    @(negedge clk);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL unlock_state got=%b exp=0", locked); end
    n_cmp++; if (ack !== 3'b100) begin n_bad++; $display("FAIL unlock_ack got=%b exp=100", ack); end
    @(posedge clk); #1;
    n_cmp++; if (grant_id !== 3'd2) begin n_bad++; $display("FAIL unlock_grant got=%0d exp=2", grant_id); end
    req = '0;
  endtask

  task automatic test_clip();
    int tx[3];
    int ty[3];
    logic tp[3];
    tx = '{159, 160, 5};
    ty = '{119, 5, 120};
    tp = '{1'b1, 1'b0, 1'b0};
    do_reset();
    req  = 3'b001;
    lock = '0;
    for (int k = 0; k < 3; k++) begin
      set_px(0, tx[k], ty[k], BLUE);
      @(negedge clk);
      n_cmp++; if (ack !== 3'b001) begin n_bad++; $display("FAIL clip_ack[%0d] got=%b exp=001", k, ack); end
      @(posedge clk); #1;
      n_cmp++; if (vga_plot !== tp[k]) begin n_bad++; $display("FAIL clip_plot[%0d] got=%b exp=%b", k, vga_plot, tp[k]); end
      n_cmp++; if (vga_x !== 8'(tx[k])) begin n_bad++; $display("FAIL clip_x[%0d] got=%0d exp=%0d", k, vga_x, tx[k]); end
      n_cmp++; if (vga_y !== 7'(ty[k])) begin n_bad++; $display("FAIL clip_y[%0d] got=%0d exp=%0d", k, vga_y, ty[k]); end
    end
    req = '0;
  endtask

  task automatic test_reset_locked();
    do_reset();
    set_px(0, 3, 4, BLUE);
    set_px(1, 7, 8, WHITE);
    set_px(2, 9, 9, WHITE);
    req  = 3'b001;
    lock = 3'b001;
    @(negedge clk);
    n_cmp++; if (ack !== 3'b001) begin n_bad++; $display("FAIL rl_ack got=%b exp=001", ack); end
    @(posedge clk); #1;
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rl_locked got=%b exp=1", locked); end
    set_px(0, 5, 4, BLUE);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL rl_reset_ack got=%b exp=000", ack); end
    @(posedge clk); #1;
    n_cmp++; if (vga_plot !== 1'b0) begin n_bad++; $display("FAIL rl_plot got=%b exp=0", vga_plot); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rl_unlocked got=%b exp=0", locked); end
    reset = 1'b0;
    req   = 3'b110;
    lock  = '0;
    @(negedge clk);
    n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL rl_post_ack got=%b exp=010", ack); end
    @(posedge clk); #1;
    n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL rl_post_grant got=%0d exp=1", grant_id); end
    n_cmp++; if (vga_x !== 8'd7) begin n_bad++; $display("FAIL rl_post_x got=%0d exp=7", vga_x); end
    req = '0;
  endtask

  task automatic test_sweep();
    int plots;
    int bad_ack;
    int bad_data;
    plots    = 0;
    bad_ack  = 0;
    bad_data = 0;
    do_reset();
    set_px(1, 77, 66, WHITE);
    req = 3'b011;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        set_px(0, x, y, BLACK);
        lock = (x == 159 && y == 119) ? 3'b000 : 3'b001;
        @(negedge clk);
        if (ack !== 3'b001) bad_ack++;
        @(posedge clk); #1;
        if (vga_plot === 1'b1) plots++;
        if (vga_plot !== 1'b1 || vga_x !== 8'(x) || vga_y !== 7'(y) || vga_colour !== BLACK) bad_data++;
      end
    end
    req  = 3'b010;
    lock = '0;
    @(negedge clk);
    n_cmp++; if (plots !== 19200) begin n_bad++; $display("FAIL sweep_plots got=%0d exp=19200", plots); end
    n_cmp++; if (bad_ack !== 0) begin n_bad++; $display("FAIL sweep_interleave got=%0d exp=0", bad_ack); end
    n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL sweep_data got=%0d exp=0", bad_data); end
    n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL sweep_next_ack got=%b exp=010", ack); end
    @(posedge clk); #1;
    n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL sweep_next_grant got=%0d exp=1", grant_id); end
    n_cmp++; if (vga_x !== 8'd77) begin n_bad++; $display("FAIL sweep_next_x got=%0d exp=77", vga_x); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_clip();
    test_reset_locked();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between NREQ pixel producers, e.g. the screen-clear sweep, the circle drawer and later shape engines.
- Arbitration is round-robin, with a lock option so one requester can keep the port for a burst (e.g. a full-screen clear).
- Plots outside the visible area are dropped.
- The VGA output is registered, one pixel per cycle maximum.

Parameters:
- NREQ, 3, number of requesters (2..8).
- X_MAX, 160, visible width; plots with x >= X_MAX are dropped.
- Y_MAX, 120, visible height; plots with y >= Y_MAX are dropped.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester pixel request; held with its data until acked.
- lock  in  NREQ  per-requester burst hold; sampled only on that requester's transfer edge.
- x_in  in  NREQ*8  packed x coordinates; requester i occupies bits [8i+7:8i].
- y_in  in  NREQ*7  packed y coordinates, same packing.
- colour_in  in  NREQ*3  packed colours, same packing.
- ack  out  NREQ  one-hot or zero; combinational; transfer occurs on a rising edge where req[i] & ack[i].
- vga_x  out  8  registered x to the VGA adapter.
- vga_y  out  7  registered y.
- vga_colour  out  3  registered colour.
- vga_plot  out  1  registered write strobe.
- grant_id  out  3  index of the last transfer winner (registered).
- locked  out  1  high while in the LOCKED state.

Behaviour:
- Reset (synchronous, checked every edge, overrides all else):
  - state = ARB, ptr = 0, owner = 0.
  - vga_x / vga_y / vga_colour / vga_plot = 0, grant_id = 0, locked = 0.
  - ack = 0 during the reset cycle.
- ARB state:
  - ack goes to the first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - No req: ack = 0, vga_plot = 0 next cycle.
- Transfer by winner w:
  - Next cycle: vga_x/y/colour = w's data, grant_id = w.
  - ptr <= (w+1) mod NREQ.
  - If lock[w]=1: state <= LOCKED, owner <= w, locked = 1.
- LOCKED state:
  - ack = req[owner] only; all other requesters wait.
  - A transfer with lock[owner]=0 returns to ARB with ptr = owner+1; that pixel is still output.
  - If req[owner]=0 and lock[owner]=0 in the same cycle, return to ARB with no transfer.
  - req[owner]=0 with lock[owner]=1 keeps the port idle but reserved.
- Latency: exactly 1 cycle from transfer edge to vga_plot=1. vga_plot is high for exactly 1 cycle per accepted in-range pixel.
- Throughput: one transfer per cycle; back-to-back transfers allowed, including alternating winners.
- Clipping: a transfer with x >= X_MAX or y >= Y_MAX is acked normally, but vga_plot = 0 that cycle. vga_x/y/colour still update, and ptr/lock handling is unchanged.
- Fairness: with all req high and no lock, grants rotate 0, 1, 2, 0, ...; no requester waits more than NREQ-1 cycles.
- Simultaneous events: lock of a non-winner is ignored. A new req arriving in LOCKED waits for lock release.
- Reset mid-LOCKED:
  - Lock is abandoned and ptr = 0.
  - Any pixel accepted on the reset edge is discarded (vga_plot = 0 next cycle).
- Data inputs are not registered; producers must hold them stable while req is high.

Decomposition:
- Shared package holds:
  - widths X_W=8, Y_W=7, C_W=3 and the VGA screen constants 160/120;
  - colour constants BLACK=3'b000, BLUE=3'b001, WHITE=3'b111;
  - state encodings ARB=1'b0, LOCKED=1'b1.
- One sub-module: rr_priority_pick (combinational rotating-priority one-hot selector, inputs req and ptr, outputs one-hot grant plus index).

Test Plan:
- Reset held 2 cycles with req=3'b111 → ack=0, vga_plot=0, grant_id=0; first edge after release acks requester 0.
- req=3'b101, no lock, data0=(10,20,BLUE), data2=(30,40,WHITE) → transfers alternate 0,2,0,2; vga_plot high every cycle; vga outputs lag the transfer by 1 cycle.
- Requester 1 transfers with lock=1 for 5 pixels while req0 and req2 are high → only ack[1] for 5 cycles, locked=1; on its last pixel (lock=0) the next grant goes to 2.
- Requester 0 sends (159,119,BLUE), then (160,5,BLUE), then (5,120,BLUE) → plot on the first only; all three acked; vga_x=160 visible with vga_plot=0.
- Reset asserted while requester 0 is locked mid-burst → next cycle vga_plot=0, locked=0; after release, req=3'b110 grants 1 first.
- Sweep: requester 0 (clear, locked) covers 160×120 while requester 1 requests → 19200 plots from 0 with no interleaving, then requester 1 served within 1 cycle.
